// File: rtl/usb_tx_encoder.sv
// usb_tx_encoder: full-speed USB TX line encoder.
// Consumes one data bit per shift_en strobe (LSB first). It applies bit
// stuffing and NRZI coding, drives D+/D-, and finishes each packet with an
// EOP of SE0 bit times followed by one J bit.
// Optional feature: define USB_TX_STUFF_CNT_EN to add the stuff_count output,
// which holds the number of stuffed bits in the current or most recent packet.
module usb_tx_encoder #(
  parameter int STUFF_LEN    = 6,
  parameter int EOP_SE0_BITS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       shift_en,
  input  logic       serial_in,
  input  logic       tx_active,
  output logic       dplus_out,
  output logic       dminus_out,
  output logic       bit_stuff_en,
  output logic       eop_done,
  output logic       tx_busy
`ifdef USB_TX_STUFF_CNT_EN
  ,
  output logic [7:0] stuff_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_TX      = 2'd1,
    S_EOP_SE0 = 2'd2,
    S_EOP_J   = 2'd3
  } state_t;

  localparam logic [2:0] STUFF_LEN_C = 3'(STUFF_LEN);
  localparam logic [1:0] EOP_BITS_C  = 2'(EOP_SE0_BITS);

  state_t     state_q, state_d;
  logic       dp_q, dp_d;
  logic       dm_q, dm_d;
  logic [2:0] ones_q, ones_d;
  logic [1:0] eop_cnt_q, eop_cnt_d;
  logic       bse_q, bse_d;
  logic       busy_q, busy_d;
  logic       eop_done_q, eop_done_d;
  logic [7:0] stuff_cnt_q, stuff_cnt_d;

  // Next-state, line and counter logic; every change is gated by the bit strobe
  always_comb begin
    state_d     = state_q;
    dp_d        = dp_q;
    dm_d        = dm_q;
    ones_d      = ones_q;
    eop_cnt_d   = eop_cnt_q;
    eop_done_d  = 1'b0;
    stuff_cnt_d = stuff_cnt_q;
    if (shift_en) begin
      case (state_q)
        S_IDLE: begin
          if (tx_active) begin
            // The strobe that starts the packet also sends its first bit.
            state_d     = S_TX;
            stuff_cnt_d = 8'd0;
            if (serial_in) begin
              ones_d = 3'd1;
            end else begin
              dp_d   = dm_q;
              dm_d   = dp_q;
              ones_d = 3'd0;
            end
          end else begin
            dp_d = 1'b1;
            dm_d = 1'b0;
          end
        end
        S_TX: begin
          if (ones_q == STUFF_LEN_C) begin
            // Stuffed zero: the line toggles and the held data bit is not consumed.
            dp_d   = dm_q;
            dm_d   = dp_q;
            ones_d = 3'd0;
            if (stuff_cnt_q != 8'hFF) begin
              stuff_cnt_d = stuff_cnt_q + 8'd1;
            end else begin
              stuff_cnt_d = stuff_cnt_q;
            end
          end else if (!tx_active) begin
            state_d   = S_EOP_SE0;
            dp_d      = 1'b0;
            dm_d      = 1'b0;
            eop_cnt_d = 2'd1;
          end else if (serial_in) begin
            ones_d = ones_q + 3'd1;
          end else begin
            dp_d   = dm_q;
            dm_d   = dp_q;
            ones_d = 3'd0;
          end
        end
        S_EOP_SE0: begin
          if (eop_cnt_q == EOP_BITS_C) begin
            state_d = S_EOP_J;
            dp_d    = 1'b1;
            dm_d    = 1'b0;
          end else begin
            eop_cnt_d = eop_cnt_q + 2'd1;
          end
        end
        S_EOP_J: begin
          state_d    = S_IDLE;
          dp_d       = 1'b1;
          dm_d       = 1'b0;
          eop_done_d = 1'b1;
        end
        default: begin
          state_d = S_IDLE;
          dp_d    = 1'b1;
          dm_d    = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    // Flags are registered from the next state, so they match a decode of the state registers.
    bse_d  = (state_d == S_TX) && (ones_d == STUFF_LEN_C);
    busy_d = (state_d != S_IDLE);
  end

  // State, line and flag registers; reset parks the line at J
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      dp_q        <= 1'b1;
      dm_q        <= 1'b0;
      ones_q      <= 3'd0;
      eop_cnt_q   <= 2'd0;
      bse_q       <= 1'b0;
      busy_q      <= 1'b0;
      eop_done_q  <= 1'b0;
      stuff_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      dp_q        <= dp_d;
      dm_q        <= dm_d;
      ones_q      <= ones_d;
      eop_cnt_q   <= eop_cnt_d;
      bse_q       <= bse_d;
      busy_q      <= busy_d;
      eop_done_q  <= eop_done_d;
      stuff_cnt_q <= stuff_cnt_d;
    end
  end

  assign dplus_out    = dp_q;
  assign dminus_out   = dm_q;
  assign bit_stuff_en = bse_q;
  assign eop_done     = eop_done_q;
  assign tx_busy      = busy_q;

`ifdef USB_TX_STUFF_CNT_EN
  assign stuff_count = stuff_cnt_q;
`else
  logic unused_stuff_cnt;
  assign unused_stuff_cnt = ^stuff_cnt_q;
`endif

endmodule

// File: tb/tb_usb_tx_encoder.sv
// tb_usb_tx_encoder: scoreboard bench for usb_tx_encoder.
// The driver expands each packet into its stuffed, NRZI-coded symbol stream.
// It queues one expected line state per strobe. A monitor checks the DUT after
// every strobe, and checks that the line and pulses stay quiet between strobes.
module tb_usb_tx_encoder;
  localparam int STUFF_LEN = 6;
  localparam int SE0_BITS  = 2;

  logic clk = 1'b0;
  logic rst;
  logic shift_en;
  logic serial_in;
  logic tx_active;
  logic dplus_out;
  logic dminus_out;
  logic bit_stuff_en;
  logic eop_done;
  logic tx_busy;
`ifdef USB_TX_STUFF_CNT_EN
  logic [7:0] stuff_count;
`endif

  usb_tx_encoder #(.STUFF_LEN(STUFF_LEN), .EOP_SE0_BITS(SE0_BITS)) dut (
    .clk(clk), .rst(rst), .shift_en(shift_en), .serial_in(serial_in),
    .tx_active(tx_active), .dplus_out(dplus_out), .dminus_out(dminus_out),
    .bit_stuff_en(bit_stuff_en), .eop_done(eop_done), .tx_busy(tx_busy)
`ifdef USB_TX_STUFF_CNT_EN
    , .stuff_count(stuff_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       dp;
    logic       dm;
    logic       bse;
    logic       busy;
    logic       eop;
    logic [7:0] scnt;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       last_exp;
  exp_t       mon_e;
  int         checks = 0;
  int         errors = 0;
  bit         mon_en = 1'b0;
  logic       strobe_seen = 1'b0;
  logic [7:0] scnt_model = 8'd0;
  logic [7:0] pkt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Remember whether the last clock edge carried a strobe.
  always @(posedge clk) strobe_seen <= shift_en;

  // Monitor: pop and compare after each strobe, and check for no change between strobes.
  always @(negedge clk) begin
    if (mon_en) begin
      if (strobe_seen) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow actual=empty expected=entry at %0t", $time);
        end else begin
          mon_e = sb_q.pop_front();
          chk("line", {30'd0, dplus_out, dminus_out}, {30'd0, mon_e.dp, mon_e.dm});
          chk("bit_stuff_en", {31'd0, bit_stuff_en}, {31'd0, mon_e.bse});
          chk("tx_busy", {31'd0, tx_busy}, {31'd0, mon_e.busy});
          chk("eop_done", {31'd0, eop_done}, {31'd0, mon_e.eop});
`ifdef USB_TX_STUFF_CNT_EN
          chk("stuff_count", {24'd0, stuff_count}, {24'd0, mon_e.scnt});
`endif
          last_exp = mon_e;
        end
      end else begin
        chk("hold_line", {30'd0, dplus_out, dminus_out}, {30'd0, last_exp.dp, last_exp.dm});
        chk("hold_bse", {31'd0, bit_stuff_en}, {31'd0, last_exp.bse});
        chk("eop_low", {31'd0, eop_done}, 32'd0);
      end
    end
  end

  task automatic strobe(input logic sin, input logic txa, input int gap);
    repeat (gap - 1) begin
      @(posedge clk); #1;
      shift_en  = 1'b0;
      serial_in = 1'($urandom);
      tx_active = 1'($urandom);
    end
    @(posedge clk); #1;
    shift_en  = 1'b1;
    serial_in = sin;
    tx_active = txa;
  endtask

  task automatic quiet(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      shift_en  = 1'b0;
      serial_in = 1'($urandom);
      tx_active = 1'b0;
    end
  endtask

  task automatic idle_strobe(input int gap);
    exp_t x;
    x = '{dp: 1'b1, dm: 1'b0, bse: 1'b0, busy: 1'b0, eop: 1'b0, scnt: scnt_model};
    sb_q.push_back(x);
    strobe(1'($urandom), 1'b0, gap);
  endtask

  // Model the packet at stream level, queue the expectations, then drive the strobes.
  task automatic send_packet(input int glo, input int ghi);
    bit   bits[$];
    bit   sv[$];
    bit   sf[$];
    int   ones;
    int   nst;
    int   idx;
    int   dleft;
    logic dp;
    logic dm;
    logic tmp;
    logic [7:0] byt;
    exp_t x;
    foreach (pkt[b]) begin
      byt = pkt[b];
      for (int i = 0; i < 8; i++) bits.push_back(byt[i]);
    end
    ones = 0;
    foreach (bits[i]) begin
      sv.push_back(bits[i]);
      sf.push_back(1'b0);
      if (bits[i]) ones++; else ones = 0;
      if (ones == STUFF_LEN) begin
        sv.push_back(1'b0);
        sf.push_back(1'b1);
        ones = 0;
      end
    end
    dp = 1'b1; dm = 1'b0; nst = 0;
    for (int k = 0; k < sv.size(); k++) begin
      if (!sv[k]) begin tmp = dp; dp = dm; dm = tmp; end
      if (sf[k]) nst++;
      x = '{dp: dp, dm: dm, bse: ((k + 1 < sv.size()) && sf[k+1]), busy: 1'b1,
            eop: 1'b0, scnt: 8'(nst)};
      sb_q.push_back(x);
    end
    for (int i = 0; i < SE0_BITS; i++) begin
      x = '{dp: 1'b0, dm: 1'b0, bse: 1'b0, busy: 1'b1, eop: 1'b0, scnt: 8'(nst)};
      sb_q.push_back(x);
    end
    x = '{dp: 1'b1, dm: 1'b0, bse: 1'b0, busy: 1'b1, eop: 1'b0, scnt: 8'(nst)};
    sb_q.push_back(x);
    x = '{dp: 1'b1, dm: 1'b0, bse: 1'b0, busy: 1'b0, eop: 1'b1, scnt: 8'(nst)};
    sb_q.push_back(x);
    scnt_model = 8'(nst);

    idx = 0;
    dleft = bits.size();
    for (int k = 0; k < sv.size(); k++) begin
      if (sf[k]) begin
        strobe(1'($urandom), (dleft > 0), $urandom_range(ghi, glo));
      end else begin
        strobe(bits[idx], 1'b1, $urandom_range(ghi, glo));
        idx++;
        dleft--;
      end
    end
    strobe(1'($urandom), 1'b0, $urandom_range(ghi, glo));
    for (int i = 1; i < SE0_BITS; i++) strobe(1'($urandom), 1'($urandom), $urandom_range(ghi, glo));
    strobe(1'($urandom), 1'b1, $urandom_range(ghi, glo));
    strobe(1'($urandom), 1'b1, $urandom_range(ghi, glo));
  endtask

  initial begin
    rst = 1'b1;
    shift_en = 1'b0;
    serial_in = 1'b0;
    tx_active = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_line", {30'd0, dplus_out, dminus_out}, 32'd2);
    chk("rst_bse", {31'd0, bit_stuff_en}, 32'd0);
    chk("rst_busy", {31'd0, tx_busy}, 32'd0);
    chk("rst_eop", {31'd0, eop_done}, 32'd0);
    rst = 1'b0;

    // Partial packet left at line K with four ones pending, then reset mid-packet.
    strobe(1'b0, 1'b1, 1);
    repeat (4) strobe(1'b1, 1'b1, 1);
    quiet(1);
    chk("pre_rst_line_k", {30'd0, dplus_out, dminus_out}, 32'd1);
    chk("pre_rst_busy", {31'd0, tx_busy}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_line", {30'd0, dplus_out, dminus_out}, 32'd2);
    chk("midrst_busy", {31'd0, tx_busy}, 32'd0);
    chk("midrst_bse", {31'd0, bit_stuff_en}, 32'd0);
    quiet(1);
    rst = 1'b0;
    quiet(1);
    last_exp = '{dp: 1'b1, dm: 1'b0, bse: 1'b0, busy: 1'b0, eop: 1'b0, scnt: 8'd0};
    scnt_model = 8'd0;
    mon_en = 1'b1;

    // A run of five ones after reset must not stuff.
    pkt = '{8'h80, 8'h0F};  send_packet(1, 2);
    idle_strobe(1);
    pkt = '{8'h80, 8'h00};  send_packet(1, 1);
    idle_strobe(2);
    pkt = '{8'h80, 8'hFF};  send_packet(1, 3);
    idle_strobe(1);
    pkt = '{8'h80, 8'h3F};  send_packet(1, 1);
    idle_strobe(1);
    pkt = '{8'h80, 8'hFF, 8'h07};  send_packet(2, 2);
    idle_strobe(3);
    // Wide strobe gaps with inputs churning in between.
    pkt = '{8'h80, 8'(($urandom & 32'h1) != 0 ? 8'hFF : 8'($urandom))};  send_packet(7, 8);
    idle_strobe(7);
    pkt = '{8'h80, 8'hC3};  send_packet(1, 1);
    for (int p = 0; p < 6; p++) begin
      pkt = '{8'h80};
      for (int b = 0; b < int'($urandom_range(3, 1)); b++) begin
        pkt.push_back((($urandom & 32'h3) == 0) ? 8'hFF : 8'($urandom));
      end
      send_packet(1, 3);
      repeat ($urandom_range(2, 0)) idle_strobe($urandom_range(3, 1));
    end
    quiet(6);
    chk("sb_empty", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
